// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } reader_state_t;

  localparam SKID_DEPTH = 2;
  localparam int OCC_WIDTH = 2;
  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(SKID_DEPTH);

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Push/pop bus between the reader control logic and its two-entry skid buffer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  import fifo_reader_pkg::*;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] head;
  logic [OCC_WIDTH-1:0]  occ;

  modport master (output push, output pop, output push_data, input head, input occ);
  modport slave  (input push, input pop, input push_data, output head, output occ);

endinterface

// File: rtl/skid_buffer_2.sv
// Two-entry in-order register FIFO; entry0 is always the head word.
module skid_buffer_2
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_stream_reader_if.slave bus
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic [OCC_WIDTH-1:0]  occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      occ    <= '0;
    end else begin
      case ({bus.push, bus.pop})
        2'b10: begin
          if (occ == '0) entry0 <= bus.push_data;
          else           entry1 <= bus.push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (occ == 2'd1) begin
            entry0 <= bus.push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= bus.push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (occ <= OCC_FULL && !(bus.push && !bus.pop && occ == OCC_FULL))
        else $error("skid_buffer_2 overflow: occ=%0d push=%0b pop=%0b", occ, bus.push, bus.pop);
    end
  end

  assign bus.head = entry0;
  assign bus.occ  = occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain FIFO consumer: issues read strobes, absorbs the one-cycle read
// latency in a skid buffer and presents a valid/ready stream with a word count.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   RCLK_top,
  input  logic                   RST_top,
  input  logic                   ENABLE_top,
  input  logic                   EMPTY_top,
  output logic                   READ_ENABLE_TOP,
  input  logic [DATA_WIDTH-1:0]  READ_DATA_IN_top,
  output logic                   M_VALID_top,
  input  logic                   M_READY_top,
  output logic [DATA_WIDTH-1:0]  M_DATA_top,
  output logic [COUNT_WIDTH-1:0] WORD_COUNT_top,
  output logic                   BUSY_top,
  output reader_state_t          state
);

  // Stream handshake: a word transfers on every rising edge where
  // M_VALID_top and M_READY_top are both high; M_DATA_top holds while stalled.
  fifo_stream_reader_if #(.DATA_WIDTH(DATA_WIDTH)) skid_bus ();

  logic                   inflight;
  logic                   pop;
  logic                   accept;
  logic [2:0]             level_after;
  logic [COUNT_WIDTH-1:0] word_count;
  reader_state_t          state_q;

  assign pop         = M_VALID_top & M_READY_top;
  // Words held or in flight once this cycle's pop has left.
  assign level_after = {1'b0, skid_bus.occ} + {2'b00, inflight} - {2'b00, pop};

  assign READ_ENABLE_TOP = RST_top & ENABLE_top & ~EMPTY_top & (level_after < 3'd2);
  assign accept          = READ_ENABLE_TOP;

  assign skid_bus.push      = inflight;
  assign skid_bus.pop       = pop;
  assign skid_bus.push_data = READ_DATA_IN_top;

  skid_buffer_2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (RCLK_top),
    .rst_n (RST_top),
    .bus   (skid_bus.slave)
  );

  always_ff @(posedge RCLK_top or negedge RST_top) begin
    if (!RST_top) begin
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
    end
  end

  always_ff @(posedge RCLK_top or negedge RST_top) begin
    if (!RST_top) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (!ENABLE_top)                             state_q <= DRAIN;
          else if (level_after == 3'd0 && !accept)     state_q <= IDLE;
        end
        DRAIN: begin
          if (ENABLE_top)                              state_q <= ACTIVE;
          else if (level_after == 3'd0)                state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge RCLK_top or negedge RST_top) begin
    if (!RST_top) begin
      word_count <= '0;
    end else if (pop && word_count != '1) begin
      word_count <= word_count + COUNT_WIDTH'(1);
    end
  end

  assign M_VALID_top    = (skid_bus.occ != '0);
  assign M_DATA_top     = skid_bus.head;
  assign WORD_COUNT_top = word_count;
  assign BUSY_top       = (state_q != IDLE);
  assign state          = state_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model and expected-word queue.
module tb_fifo_stream_reader;
  import fifo_reader_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          empty_in = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] read_data = '0;

  logic          rd_en, m_valid, busy;
  logic [DW-1:0] m_data;
  logic [15:0]   word_count;
  reader_state_t state;

  logic          rd_en_s, m_valid_s, busy_s;
  logic [DW-1:0] m_data_s;
  logic [3:0]    word_count_s;
  reader_state_t state_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int strobe_cnt = 0;
  int first_strobe = -1;
  int s0, s1, p0;

  logic          empty_force = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pop_cycles[$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) dut (
    .RCLK_top         (clk),
    .RST_top          (rst_n),
    .ENABLE_top       (enable),
    .EMPTY_top        (empty_in),
    .READ_ENABLE_TOP  (rd_en),
    .READ_DATA_IN_top (read_data),
    .M_VALID_top      (m_valid),
    .M_READY_top      (m_ready),
    .M_DATA_top       (m_data),
    .WORD_COUNT_top   (word_count),
    .BUSY_top         (busy),
    .state            (state)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) dut_sat (
    .RCLK_top         (clk),
    .RST_top          (rst_n),
    .ENABLE_top       (enable),
    .EMPTY_top        (empty_in),
    .READ_ENABLE_TOP  (rd_en_s),
    .READ_DATA_IN_top (read_data),
    .M_VALID_top      (m_valid_s),
    .M_READY_top      (m_ready),
    .M_DATA_top       (m_data_s),
    .WORD_COUNT_top   (word_count_s),
    .BUSY_top         (busy_s),
    .state            (state_s)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    empty_in = empty_force || (fifo_q.size() == 0);
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_empty();
  endtask

  // One clock: sample at the falling edge, apply FIFO read data after the rising edge.
  task automatic step();
    logic acc, pop_now;
    @(negedge clk);
    acc     = rd_en && !empty_in;
    pop_now = m_valid && m_ready;
    check("strobe_while_empty", 32'(rd_en && empty_in), 0);
    if (stall_prev) check("stall_data_stable", 32'(m_data), 32'(stall_data));
    stall_prev = m_valid && !m_ready;
    stall_data = m_data;
    if (acc) begin
      acc_cnt++;
      strobe_cnt++;
      if (first_strobe < 0) first_strobe = cyc;
    end
    if (pop_now) begin
      pop_cnt++;
      pop_cycles.push_back(cyc);
      check("pop_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    check("outstanding_le2", 32'((acc_cnt - pop_cnt) <= 2), 1);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) read_data = fifo_q.pop_front();
    update_empty();
  endtask

  initial begin
    // Reset with random inputs; first pass forces a would-be strobe.
    for (int i = 0; i < 4; i++) begin
      enable    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      empty_in  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      m_ready   = 1'($urandom_range(0, 1));
      read_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_valid", 32'(m_valid), 0);
      check("rst_data", 32'(m_data), 0);
      check("rst_count", 32'(word_count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(state), 32'(IDLE));
      @(posedge clk);
      #1;
    end
    enable  = 1'b1;
    m_ready = 1'b1;
    update_empty();
    rst_n = 1'b1;
    repeat (3) step();
    check("no_strobe_while_empty", 32'(strobe_cnt), 0);

    // Full-rate stream of 19 words
    for (int i = 1; i <= 15; i++) load(8'(i * 17));
    load(8'h01);
    load(8'h03);
    load(8'h05);
    load(8'h06);
    first_strobe = -1;
    pop_cycles.delete();
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) step();
    check("full_drained", 32'(exp_q.size()), 0);
    check("full_pops", 32'(pop_cycles.size()), 19);
    for (int k = 0; k < pop_cycles.size(); k++)
      check("full_pop_cycle", 32'(pop_cycles[k]), 32'(first_strobe + 2 + k));
    check("full_count", 32'(word_count), 19);
    check("full_busy_low", 32'(busy), 0);
    check("full_state_idle", 32'(state), 32'(IDLE));

    // Backpressure for 10 cycles mid-stream
    for (int i = 0; i < 12; i++) load(8'(8'h30 + i));
    m_ready = 1'b1;
    repeat (4) step();
    m_ready = 1'b0;
    s0 = strobe_cnt;
    repeat (10) step();
    check("bp_strobes_in_stall", 32'(strobe_cnt - s0), 0);
    check("bp_valid_held", 32'(m_valid), 1);
    check("bp_buffer_full", 32'(acc_cnt - pop_cnt), 2);
    check("bp_no_strobe_full", 32'(rd_en), 0);
    check("bp_count_frozen", 32'(word_count), 21);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check("bp_drained", 32'(exp_q.size()), 0);
    check("bp_count", 32'(word_count), 31);
    check("bp_busy_low", 32'(busy), 0);

    // Pseudo-random EMPTY toggling and backpressure
    for (int i = 0; i < 16; i++) load(8'(8'hA0 + i));
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      empty_force = 1'($urandom_range(0, 1));
      m_ready     = ($urandom_range(0, 3) != 0);
      update_empty();
      step();
    end
    empty_force = 1'b0;
    m_ready     = 1'b1;
    update_empty();
    check("eg_drained", 32'(exp_q.size()), 0);
    check("eg_count", 32'(word_count), 47);
    check("eg_busy_low", 32'(busy), 0);

    // ENABLE drops at the edge ending an accepted read
    m_ready = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 6; i++) load(8'(8'hC0 + i));
    s0 = strobe_cnt;
    for (int i = 0; i < 10 && (strobe_cnt - s0) < 2; i++) step();
    check("ed_two_strobes", 32'(strobe_cnt - s0), 2);
    enable = 1'b0;
    check("ed_state_active", 32'(state), 32'(ACTIVE));
    s1 = strobe_cnt;
    step();
    check("ed_state_drain", 32'(state), 32'(DRAIN));
    m_ready = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 10 && (pop_cnt - p0) < 2; i++) step();
    check("ed_delivered", 32'(pop_cnt - p0), 2);
    check("ed_state_idle", 32'(state), 32'(IDLE));
    repeat (2) step();
    check("ed_no_strobes", 32'(strobe_cnt - s1), 0);
    check("ed_busy_low", 32'(busy), 0);
    check("ed_fifo_left", 32'(fifo_q.size()), 4);
    check("ed_count", 32'(word_count), 49);
    check("sat_count_hold", 32'(word_count_s), 15);

    // Asynchronous reset with both buffer entries full
    enable  = 1'b1;
    m_ready = 1'b0;
    repeat (4) step();
    check("mr_valid", 32'(m_valid), 1);
    check("mr_buffer_full", 32'(acc_cnt - pop_cnt), 2);
    check("mr_fifo_left", 32'(fifo_q.size()), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid_async", 32'(m_valid), 0);
    check("mr_sat_valid_async", 32'(m_valid_s), 0);
    check("mr_count_async", 32'(word_count), 0);
    check("mr_busy_async", 32'(busy), 0);
    check("mr_rd_en_async", 32'(rd_en), 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    acc_cnt    = 0;
    pop_cnt    = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    update_empty();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    check("mr_drained", 32'(exp_q.size()), 0);
    check("mr_count", 32'(word_count), 2);
    check("mr_sat_count", 32'(word_count_s), 2);
    check("mr_busy_low", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
